// File: rtl/elevator_pkg.sv
// ============================================================================
// elevator_pkg : shared constants and monitor state encoding | rev 1.0
// ============================================================================
`default_nettype none

package elevator_pkg;

  // Shared with the clock divider so both ends agree on the half-period.
  localparam int TOGGLE_VALUE_DEFAULT = 1000000;

  typedef logic [1:0] mon_state_t;

  localparam mon_state_t ST_SEARCH  = 2'd0;
  localparam mon_state_t ST_ACQUIRE = 2'd1;
  localparam mon_state_t ST_LOCKED  = 2'd2;
  localparam mon_state_t ST_LOST    = 2'd3;

endpackage

`default_nettype wire

// File: rtl/sync_edge_detect.sv
// ============================================================================
// sync_edge_detect : 2-flop synchroniser, history flop, rise/fall strobes | rev 1.0
// ============================================================================
`default_nettype none

module sync_edge_detect (
  input  logic clk_in,
  input  logic rst,
  input  logic din,
  output logic edge_det,
  output logic rise_tick,
  output logic fall_tick
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;
  logic rise_tick_q, rise_tick_d;
  logic fall_tick_q, fall_tick_d;

  always_comb begin
    s1_d        = din;
    s2_d        = s1_q;
    s3_d        = s2_q;
    rise_tick_d = s2_q & ~s3_q;
    fall_tick_d = ~s2_q & s3_q;
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      rise_tick_q <= 1'b0;
      fall_tick_q <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      rise_tick_q <= rise_tick_d;
      fall_tick_q <= fall_tick_d;
    end
  end

  // Unregistered edge lets the consumer act on the same clock edge that raises the tick.
  assign edge_det  = s2_q ^ s3_q;
  assign rise_tick = rise_tick_q;
  assign fall_tick = fall_tick_q;

endmodule

`default_nettype wire

// File: rtl/div_clk_monitor.sv
// ============================================================================
// div_clk_monitor : divided-clock edge strobes, half-period measure, lock FSM | rev 1.0
// ============================================================================
`default_nettype none

module div_clk_monitor
  import elevator_pkg::*;
#(
  parameter int TOGGLE_VALUE = TOGGLE_VALUE_DEFAULT,
  parameter int TOL          = 4,
  parameter int LOCK_COUNT   = 4,
  parameter int CNT_W        = 25
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             slow_clk,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic             locked,
  output logic             lost,
  output logic [CNT_W-1:0] half_period
);

  localparam int EXP = TOGGLE_VALUE + 1;
  localparam int MW  = CNT_W + 1;
  localparam int GW  = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);

  localparam logic [MW-1:0]    MEAS_LO   = (EXP > TOL) ? MW'(EXP - TOL) : MW'(1);
  localparam logic [MW-1:0]    MEAS_HI   = MW'(EXP + TOL);
  localparam logic [CNT_W-1:0] TMO_CNT   = CNT_W'(EXP + TOL);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [GW-1:0]    GOOD_LOCK = GW'(LOCK_COUNT);

  logic             edge_det;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GW-1:0]    good_q, good_d;
  logic [CNT_W-1:0] half_period_q, half_period_d;
  mon_state_t       state_q, state_d;

  logic [MW-1:0]    meas;
  logic [CNT_W-1:0] meas_sat;
  logic [GW-1:0]    good_inc;
  logic             meas_good;
  logic             timeout;

  sync_edge_detect u_sync (
    .clk_in    (clk_in),
    .rst       (rst),
    .din       (slow_clk),
    .edge_det  (edge_det),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (edge_det) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Measurement is one wider so a saturated counter cannot wrap into range.
  always_comb begin
    meas      = {1'b0, cnt_q} + MW'(1);
    meas_sat  = meas[CNT_W] ? CNT_MAX : meas[CNT_W-1:0];
    meas_good = (meas >= MEAS_LO) && (meas <= MEAS_HI);
    timeout   = (cnt_q == TMO_CNT) && !edge_det;
    good_inc  = good_q + GW'(1);
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cnt_q         <= '0;
      good_q        <= '0;
      half_period_q <= '0;
      state_q       <= ST_SEARCH;
    end else begin
      cnt_q         <= cnt_d;
      good_q        <= good_d;
      half_period_q <= half_period_d;
      state_q       <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    good_d        = good_q;
    half_period_d = half_period_q;
    case (state_q)
      ST_SEARCH: begin
        if (edge_det) begin
          state_d = ST_ACQUIRE;
          good_d  = '0;
        end
      end
      ST_ACQUIRE: begin
        if (edge_det) begin
          half_period_d = meas_sat;
          if (meas_good) begin
            good_d = good_inc;
            if (good_inc == GOOD_LOCK) begin
              state_d = ST_LOCKED;
            end
          end else begin
            good_d = '0;
          end
        end else if (timeout) begin
          good_d = '0;
        end
      end
      ST_LOCKED: begin
        if (edge_det) begin
          half_period_d = meas_sat;
          if (!meas_good) begin
            state_d = ST_LOST;
          end
        end else if (timeout) begin
          state_d = ST_LOST;
        end
      end
      ST_LOST: begin
        if (edge_det) begin
          state_d = ST_ACQUIRE;
          good_d  = '0;
        end
      end
      default: begin
        state_d = ST_SEARCH;
        good_d  = '0;
      end
    endcase
  end

  always_comb begin
    locked      = (state_q == ST_LOCKED);
    lost        = (state_q == ST_LOST);
    half_period = half_period_q;
  end

endmodule

`default_nettype wire

// File: doc/div_clk_monitor.md
# div_clk_monitor

Consumer-side checker for the slow clock produced by the design's clock divider. It synchronises the divided clock into the `clk_in` domain and emits one-cycle rise/fall strobes for downstream FSMs (floor timers, door timers, display refresh). It also measures every half-period and tracks a lock state, so a stalled or mis-programmed divider is flagged instead of silently freezing the elevator controller.

## Interface
Parameters:
- `TOGGLE_VALUE`, default 1000000. Divider setting being monitored. The expected half-period is `EXP = TOGGLE_VALUE+1` clk_in cycles.
- `TOL`, default 4. Allowed deviation of a half-period from `EXP`, in cycles (inclusive).
- `LOCK_COUNT`, default 4. Number of consecutive in-tolerance half-periods required to declare lock.
- `CNT_W`, default 25. Counter width. Must satisfy `2^CNT_W-1 >= EXP+TOL+1`.

Ports:
- `clk_in`: input, 1 bit. System clock (100 MHz).
- `rst`: input, 1 bit. Reset; asynchronous, active-low.
- `slow_clk`: input, 1 bit. The divided clock, treated as asynchronous data. It is never used as a clock.
- `rise_tick`: output, 1 bit. One-cycle strobe per detected rising edge of `slow_clk`.
- `fall_tick`: output, 1 bit. One-cycle strobe per detected falling edge of `slow_clk`.
- `locked`: output, 1 bit. High only in the LOCKED state.
- `lost`: output, 1 bit. High only in the LOST state.
- `half_period`: output, `CNT_W` bits. Last measured edge-to-edge distance in clk_in cycles.

## Operation
- **Synchroniser.** `slow_clk` passes through two flops (`s1`, `s2`), then a history flop `s3`.
  - `edge = s2 ^ s3`.
  - rise = `s2 & ~s3`; fall = `~s2 & s3`.
- **Ticks.** `rise_tick` and `fall_tick` are registered versions of rise and fall. They can never be high together.
- **Counter `cnt`.**
  - Cleared to 0 on every clk_in edge where `edge` is true.
  - Otherwise increments by 1, saturating at `2^CNT_W-1`.
- **Measurement.**
  - On an edge, `meas = cnt+1`.
  - A measurement is good when `EXP-TOL <= meas <= EXP+TOL`, using unsigned compare.
  - When `EXP < TOL`, the lower bound clamps to 1.
- **Timeout.** True when `cnt == EXP+TOL` and `edge` is false.
- **`half_period`.** Loads `meas` on every edge, except when the current state is SEARCH or LOST (those measurements are invalid).
- **FSM** (states SEARCH, ACQUIRE, LOCKED, LOST; `good` counter 0..LOCK_COUNT):
  - SEARCH (state after reset):
    - Any edge → ACQUIRE, with `good=0`.
  - ACQUIRE:
    - Good measurement → `good+1`. When the incremented value reaches `LOCK_COUNT`, go to LOCKED.
    - Bad measurement or timeout → `good=0`, stay in ACQUIRE.
  - LOCKED:
    - Bad measurement or timeout → LOST.
  - LOST:
    - Next edge → ACQUIRE, with `good=0`.
- **Simultaneous events.** An edge in the same cycle as the timeout condition cannot happen by definition: the edge wins and is evaluated as a measurement.
- **Reset.** Asynchronous assertion at any time, including mid-lock, forces:
  - `s1`, `s2`, `s3` = 0;
  - `cnt` = 0;
  - `good` = 0;
  - state = SEARCH;
  - all outputs to their reset values.
- **Reset values of outputs:** `rise_tick` = 0, `fall_tick` = 0, `locked` = 0, `lost` = 0, `half_period` = 0.
- **Reset release with `slow_clk` high.** This produces one `rise_tick`. It is absorbed in SEARCH and is not an error.

## Timing
- **Tick latency.** A `slow_clk` transition that is stable before clk_in edge k appears as a tick during the cycle after edge k+2. That is 3 clk_in edges, with ±1 cycle of synchroniser uncertainty.
- **Tick width.** Each tick is exactly 1 cycle.
- **Edge spacing.** Consecutive edges with steady input are `EXP` cycles apart.
- **State and `half_period` update.** Both update on the same clk_in edge that raises the tick.
- **`locked` rise.** Occurs with the tick of the (LOCK_COUNT+1)-th edge after SEARCH or LOST exit.
- **Timeout to `lost`.** `lost` rises `EXP+TOL+1` cycles after the last tick when no further edge arrives.
- **Throughput.** No handshake. Strobes are fire-and-forget, and consumers must sample them every cycle.

## Structure
- **Shared package `elevator_pkg`:**
  - state encoding: SEARCH=2'd0, ACQUIRE=2'd1, LOCKED=2'd2, LOST=2'd3;
  - default `TOGGLE_VALUE` constant, shared with the clock divider so both ends agree.
- **Sub-module `sync_edge_detect`:** the 2-flop synchroniser, history flop, and registered rise/fall strobes. It is reused for the button inputs.
- **Top level:** counter, tolerance compare, FSM.

## Test plan
Bench parameters: `TOGGLE_VALUE=9` (`EXP=10`), `TOL=1`, `LOCK_COUNT=4`, `CNT_W=8`.

1. **Steady toggling.** `slow_clk` toggles every 10 cycles → ticks alternate rise/fall, 10 cycles apart, each 3 cycles after its transition. `half_period=10`. `locked` rises at the 5th tick.
2. **Tolerance bounds.** While locked, a half-period of 11, then 9 → `locked` stays 1 and `half_period` shows 11, then 9. A half-period of 12 → `locked=0` and `lost=1` on that tick.
3. **Stall.** Hold `slow_clk` while locked → `lost` rises 12 cycles after the last tick. `cnt` keeps counting and `half_period` is unchanged.
4. **Recovery.** From LOST, resume 10-cycle toggling → the first edge enters ACQUIRE without updating `half_period`. `locked` returns on the 5th tick after resumption.
5. **Glitch.** A 1-cycle-wide `slow_clk` pulse while locked → rise and fall ticks 1 cycle apart, measurement 1, transition to LOST.
6. **Async reset mid-operation.** Drop `rst` mid-lock, asynchronous to `clk_in` → all outputs are 0 immediately. After release with `slow_clk=1` → one `rise_tick` and state ACQUIRE; no `lost`.
